dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arb_starve.sv | 40 ++++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DMA  = 2'd2
  } owner_t;

  localparam int          STARVE_LIMIT_DEF = 4;
  localparam logic [31:0] MMIO_BASE_DEF    = 32'hC000_0000;

  // DMA may never touch the MMIO window at or above the base.
  function automatic logic is_mmio(input logic [31:0] addr, input logic [31:0] base);
    return (addr >= base);
  endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// Saturating starvation counter: counts CPU wins while DMA waits.
// Latency: count updates at the clock edge; hit is a direct decode of the count.
// Backpressure: none; clear has priority over increment.
module dmem_arb_starve #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [2:0] LIM = 3'(LIMIT);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 3'd0;
    end else if (inc && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master (CPU, DMA) arbiter onto one combinational-read data memory port.
// Latency: grant and memory strobes in the request cycle; read data one cycle later.
// Backpressure: requesters hold req until gnt; CPU wins unless DMA has starved STARVE_LIMIT grants.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter logic [31:0] MMIO_BASE    = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic [1:0]  owner
);

  logic        starve_hit;
  logic        dma_sel;
  logic        starve_clr;
  logic        starve_inc;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        dma_rvalid_q, dma_rvalid_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;
  owner_t      owner_q, owner_d;

  // Select a winner; reset kills every grant so nothing leaks out while it is held.
  always_comb begin
    dma_sel = 1'b0;
    cpu_gnt = 1'b0;
    if (!reset) begin
      dma_sel = dma_req && (!cpu_req || starve_hit);
      cpu_gnt = cpu_req && !dma_sel;
    end
    dma_gnt = dma_sel && !is_mmio(dma_addr, MMIO_BASE);
    dma_err = dma_sel && is_mmio(dma_addr, MMIO_BASE);
    mem_a   = dma_gnt ? dma_addr  : cpu_addr;
    mem_wd  = dma_gnt ? dma_wdata : cpu_wdata;
    mem_we  = (cpu_gnt && cpu_we) || (dma_gnt && dma_we);
  end

  // Starvation is only meaningful while DMA is actually waiting.
  always_comb begin
    starve_clr = dma_gnt || dma_err || !dma_req;
    starve_inc = cpu_gnt && dma_req;
  end

  dmem_arb_starve #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .clr   (starve_clr),
    .inc   (starve_inc),
    .hit   (starve_hit)
  );

  // Capture read data for the granted reader; the other side keeps its last value.
  always_comb begin
    cpu_rvalid_d = cpu_gnt && !cpu_we;
    dma_rvalid_d = dma_gnt && !dma_we;
    cpu_rdata_d  = cpu_rvalid_d ? mem_rd : cpu_rdata_q;
    dma_rdata_d  = dma_rvalid_d ? mem_rd : dma_rdata_q;
  end

  // Read-return registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      dma_rdata_q  <= 32'd0;
    end else begin
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // Owner follows whoever won the previous cycle; a rejected DMA counts as no winner.
  always_comb begin
    owner_d = IDLE;
    if (dma_gnt) begin
      owner_d = DMA;
    end else if (cpu_gnt) begin
      owner_d = CPU;
    end
  end

  // Owner state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign owner      = owner_q;

endmodule
